// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the two-requester ALU scheduler.
package alu_sched_pkg;
   localparam int ALU_W = 4;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_NOT = 3'b010,
      OP_AND = 3'b011,
      OP_OR  = 3'b100,
      OP_XOR = 3'b101,
      OP_SLT = 3'b110,
      OP_EQ  = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_RESP
   } sched_state_e;
endpackage

// File: rtl/alu_core.sv
// Purely combinational 8-op ALU: (a, b, op) -> (res, carry, signed overflow).
module alu_core
   import alu_sched_pkg::*;
#(
   parameter int W = ALU_W
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic [2:0]   i_op,
   output logic [W-1:0] o_res,
   output logic         o_car,
   output logic         o_of
);

   logic [W:0] w_sum;

   always_comb begin
      w_sum = '0;
      o_res = '0;
      o_car = 1'b0;
      o_of  = 1'b0;
      case (alu_op_e'(i_op))
         OP_ADD: begin
            w_sum = {1'b0, i_a} + {1'b0, i_b};
            o_res = w_sum[W-1:0];
            o_car = w_sum[W];
            o_of  = (i_a[W-1] == i_b[W-1]) && (o_res[W-1] != i_a[W-1]);
         end
         OP_SUB: begin
            // carry-out is "no borrow", so 0-0 reports car=1
            w_sum = {1'b0, i_a} + {1'b0, ~i_b} + {{W{1'b0}}, 1'b1};
            o_res = w_sum[W-1:0];
            o_car = w_sum[W];
            o_of  = (i_a[W-1] != i_b[W-1]) && (o_res[W-1] != i_a[W-1]);
         end
         OP_NOT: o_res = ~i_a;
         OP_AND: o_res = i_a & i_b;
         OP_OR:  o_res = i_a | i_b;
         OP_XOR: o_res = i_a ^ i_b;
         OP_SLT: o_res = {{(W-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
         OP_EQ:  o_res = {{(W-1){1'b0}}, (i_a == i_b)};
         default: o_res = '0;
      endcase
   end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one alu_core between two valid/ready clients.
// ALU_SCHED_FAST_EN: drop EXEC and register the ALU result at the accept edge.
module alu_sched
   import alu_sched_pkg::*;
#(
   parameter int W     = ALU_W,
   parameter int N_REQ = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req_valid,
   output logic [N_REQ-1:0]   req_ready,
   input  logic [N_REQ*W-1:0] req_a,
   input  logic [N_REQ*W-1:0] req_b,
   input  logic [N_REQ*3-1:0] req_op,
   output logic [N_REQ-1:0]   rsp_valid,
   input  logic [N_REQ-1:0]   rsp_ready,
   output logic [W-1:0]       rsp_res,
   output logic               rsp_car,
   output logic               rsp_of,
   output logic               busy
);

   sched_state_e r_state, w_next;
   logic         r_ptr, r_gid, w_gid, w_acc, w_done;
   logic [W-1:0] w_sel_a, w_sel_b, w_alu_a, w_alu_b, w_res;
   logic [2:0]   w_sel_op, w_alu_op;
   logic         w_car, w_of;

   // Contention goes to the pointer holder; otherwise the lone requester.
   assign w_gid    = (&req_valid) ? r_ptr : req_valid[1];
   assign w_sel_a  = w_gid ? req_a[2*W-1:W] : req_a[W-1:0];
   assign w_sel_b  = w_gid ? req_b[2*W-1:W] : req_b[W-1:0];
   assign w_sel_op = w_gid ? req_op[5:3]    : req_op[2:0];
   assign busy     = (r_state != S_IDLE);

`ifdef ALU_SCHED_FAST_EN
   assign w_alu_a  = w_sel_a;
   assign w_alu_b  = w_sel_b;
   assign w_alu_op = w_sel_op;
`else
   logic [W-1:0] r_a, r_b;
   logic [2:0]   r_op;
   assign w_alu_a  = r_a;
   assign w_alu_b  = r_b;
   assign w_alu_op = r_op;
`endif

   alu_core #(.W(W)) u_alu (
      .i_a   (w_alu_a),
      .i_b   (w_alu_b),
      .i_op  (w_alu_op),
      .o_res (w_res),
      .o_car (w_car),
      .o_of  (w_of)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      req_ready = '0;
      rsp_valid = '0;
      w_acc     = 1'b0;
      w_done    = 1'b0;
      case (r_state)
         S_IDLE: begin
            // gated by rst_n so nothing looks accepted while held in reset
            if ((|req_valid) && rst_n) begin
               w_acc            = 1'b1;
               req_ready[w_gid] = 1'b1;
`ifdef ALU_SCHED_FAST_EN
               w_next           = S_RESP;
`else
               w_next           = S_EXEC;
`endif
            end
         end
         S_EXEC: w_next = S_RESP;
         S_RESP: begin
            rsp_valid[r_gid] = 1'b1;
            if (rsp_ready[r_gid]) begin
               w_done = 1'b1;
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ptr   <= 1'b0;
         r_gid   <= 1'b0;
         rsp_res <= '0;
         rsp_car <= 1'b0;
         rsp_of  <= 1'b0;
`ifndef ALU_SCHED_FAST_EN
         r_a     <= '0;
         r_b     <= '0;
         r_op    <= '0;
`endif
      end else begin
         if (w_acc) begin
            r_gid <= w_gid;
`ifdef ALU_SCHED_FAST_EN
            rsp_res <= w_res;
            rsp_car <= w_car;
            rsp_of  <= w_of;
`else
            r_a  <= w_sel_a;
            r_b  <= w_sel_b;
            r_op <= w_sel_op;
`endif
         end
`ifndef ALU_SCHED_FAST_EN
         if (r_state == S_EXEC) begin
            rsp_res <= w_res;
            rsp_car <= w_car;
            rsp_of  <= w_of;
         end
`endif
         if (w_done) r_ptr <= ~r_gid;
      end
   end

endmodule
